instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: DEPTH, 4, output FIFO entries (power of two, >=2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  encode request present.
REQ-005 in_ready  output  1  request accepted this cycle when in_valid && in_ready.
REQ-006 req_type  input  2  00 data-processing, 01 load/store, 10 branch, 11 illegal.
REQ-007 req_cond  input  4  condition field.
REQ-008 req_imm  input  1  I flag (DP/LS only).
REQ-009 req_opcode  input  4  DP opcode, or {P,U,B,W} for LS.
REQ-010 req_s  input  1  S bit (DP), L bit (LS), link bit (branch).
REQ-011 req_rn  input  4  base/first-operand register.
REQ-012 req_rd  input  4  destination/source register.
REQ-013 req_operand  input  24  operand2/offset (DP/LS use [11:0]); branch offset [23:0].
REQ-014 out_valid  output  1  FIFO head holds an instruction.
REQ-015 out_ready  input  1  consumer takes head when out_valid && out_ready.
REQ-016 out_instr  output  32  encoded instruction at FIFO head.
REQ-017 fifo_count  output  $clog2(DEPTH)+1  entries currently held.
REQ-018 instr_count  output  16  instructions popped since reset.
REQ-019 err  output  1  one-cycle pulse on accepted illegal request.

Function
REQ-020 DP word SHALL be {cond, 2'b00, imm, opcode, s, rn, rd, operand[11:0]}.
REQ-021 LS word SHALL be {cond, 2'b01, imm, opcode, s, rn, rd, operand[11:0]}.
REQ-022 Branch word SHALL be {cond, 3'b101, s, operand[23:0]}; req_imm, req_opcode, req_rn, req_rd ignored.
REQ-023 Accepted req_type 11 SHALL pulse err the next cycle, enqueue nothing, leave FIFO unchanged.
REQ-024 FSM states IDLE and NOP_FILL; in_ready SHALL be (state==IDLE) && (fifo_count<DEPTH), independent of out_ready.
REQ-025 Accepted legal request SHALL be written to FIFO tail at the accepting edge; out_valid visible the following cycle (latency 1, no bypass).
REQ-026 out_valid SHALL equal (fifo_count!=0); out_instr SHALL be 0 when empty.
REQ-027 Simultaneous push and pop SHALL keep fifo_count constant and preserve FIFO order.
REQ-028 Pointers SHALL wrap modulo DEPTH; instr_count SHALL wrap 0xFFFF->0x0000.
REQ-029 NOP_FILL: push 32'h00000000 on first cycle fifo_count<DEPTH (or a pop frees a slot at that edge), then return to IDLE.
REQ-030 out_ready while empty SHALL have no effect; instr_count increments only on actual pop.

Reset
REQ-031 On reset: state IDLE, fifo_count 0, pointers 0, out_valid 0, out_instr 0, instr_count 0, err 0.
REQ-032 in_ready SHALL be 0 during the reset cycle.
REQ-033 Reset during NOP_FILL SHALL discard the pending NOP and all FIFO contents.

Configuration
REQ-034 Macro INSTR_ENCODER_NOP_FILL_EN defined: accepted branch moves FSM to NOP_FILL, inserting one NOP (delay slot) after the branch.
REQ-035 Macro undefined: FSM stays IDLE permanently; branches enqueue alone; no NOP inserted.

Verification
REQ-036 DP: cond E, type 00, imm 1, opcode 0100, s 1, rn 1, rd 2, operand 0x005, out_ready 1 -> next cycle out_instr 0xE2912005, instr_count 1.
REQ-037 LS: cond E, type 01, imm 0, opcode 1100, s 1, rn 3, rd 4, operand 0x010 -> out_instr 0xE5934010.
REQ-038 Branch (NOP_FILL_EN): cond E, type 10, s 0, operand 0x000003 -> 0xEA000003 then 0x00000000; in_ready 0 for exactly one cycle; without macro only 0xEA000003, in_ready stays 1.
REQ-039 Full: out_ready 0, push DEPTH DP requests -> fifo_count DEPTH, in_ready 0; then in_valid and out_ready 1 -> one pop per cycle, order intact, count never exceeds DEPTH.
REQ-040 Illegal: type 11 accepted -> err 1 for one cycle, fifo_count unchanged; reset asserted in NOP_FILL -> next cycle fifo_count 0, out_valid 0, in_ready 1 after release.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: encodes DP/LS/branch requests into 32-bit words queued in an output FIFO
// Optional INSTR_ENCODER_NOP_FILL_EN: insert one NOP delay slot after every accepted branch.
module instr_encoder #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 req_type,
    input  logic [3:0]                 req_cond,
    input  logic                       req_imm,
    input  logic [3:0]                 req_opcode,
    input  logic                       req_s,
    input  logic [3:0]                 req_rn,
    input  logic [3:0]                 req_rd,
    input  logic [23:0]                req_operand,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [15:0]                instr_count,
    output logic                       err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {IDLE, NOP_FILL} state_t;

    state_t          state, next_state;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [31:0]     word;
    logic            accept, legal_push, nop_push, push, pop;

    assign in_ready  = !reset && state == IDLE && fifo_count < FULL;
    assign out_valid = fifo_count != '0;
    assign out_instr = out_valid ? mem[rd_ptr] : '0;

    // Handshakes and the word to enqueue; a pending NOP may use a slot freed by a same-edge pop
    always_comb begin
        accept     = in_valid && in_ready;
        legal_push = accept && req_type != 2'b11;
        pop        = out_valid && out_ready;
        nop_push   = state == NOP_FILL && (fifo_count < FULL || pop);
        push       = legal_push || nop_push;
        word       = nop_push ? 32'h0 :
                     req_type == 2'b10 ? {req_cond, 3'b101, req_s, req_operand} :
                     {req_cond, 1'b0, req_type[0], req_imm, req_opcode, req_s, req_rn, req_rd, req_operand[11:0]};
    end

    // Next state: a branch opens a NOP delay slot when the feature is built in
    always_comb begin
        next_state = state;
`ifdef INSTR_ENCODER_NOP_FILL_EN
        if (state == IDLE && legal_push && req_type == 2'b10) next_state = NOP_FILL;
        else if (nop_push) next_state = IDLE;
`else
        next_state = IDLE;
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        state <= reset ? IDLE : next_state;
    end

    // FIFO storage, pointers, occupancy, pop counter and illegal-request pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            instr_count <= '0;
            err         <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= word;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                instr_count <= instr_count + 16'd1;
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            err        <= accept && req_type == 2'b11;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed-vector self-checking bench for instr_encoder
module tb_instr_encoder;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, req_imm, req_s, out_valid, out_ready, err;
    logic [1:0]  req_type;
    logic [3:0]  req_cond, req_opcode, req_rn, req_rd;
    logic [23:0] req_operand;
    logic [31:0] out_instr;
    logic [2:0]  fifo_count;
    logic [15:0] instr_count;

    int checks = 0;
    int errors = 0;
    int exp_ic = 0;
    logic [31:0] q[$];

    instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .req_type(req_type), .req_cond(req_cond), .req_imm(req_imm),
        .req_opcode(req_opcode), .req_s(req_s), .req_rn(req_rn), .req_rd(req_rd),
        .req_operand(req_operand), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .fifo_count(fifo_count), .instr_count(instr_count),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] t, input logic [3:0] c, input logic i,
                         input logic [3:0] op, input logic s, input logic [3:0] rn,
                         input logic [3:0] rd, input logic [23:0] opd);
        in_valid = 1'b1; req_type = t; req_cond = c; req_imm = i; req_opcode = op;
        req_s = s; req_rn = rn; req_rd = rd; req_operand = opd;
    endtask

    // DP word for cond E, imm 1, opcode 0100, s 1, rn 1 with the given rd and 12-bit operand
    function automatic logic [31:0] dp_word(input logic [3:0] rd, input logic [11:0] opd);
        return 32'hE2910000 | {16'h0, rd, 12'h0} | {20'h0, opd};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        req_type = '0; req_cond = '0; req_imm = 1'b0; req_opcode = '0;
        req_s = 1'b0; req_rn = '0; req_rd = '0; req_operand = '0;
        step;
        check("rst_in_ready", in_ready, 0);
        check("rst_count", fifo_count, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_instr", out_instr, 0);
        check("rst_instr_count", instr_count, 0);
        check("rst_err", err, 0);
        reset = 1'b0;
        #1 check("post_rst_in_ready", in_ready, 1);

        out_ready = 1'b1;
        drive(2'b00, 4'hE, 1'b1, 4'b0100, 1'b1, 4'd1, 4'd2, 24'h5);
        step;
        in_valid = 1'b0;
        check("dp_valid", out_valid, 1);
        check("dp_word", out_instr, 32'hE2912005);
        check("dp_count", fifo_count, 1);
        step;
        exp_ic = 1;
        check("dp_popped", instr_count, exp_ic);
        check("dp_empty_count", fifo_count, 0);
        check("dp_empty_word", out_instr, 0);
        step;
        check("empty_pop_ic", instr_count, exp_ic);
        check("empty_pop_count", fifo_count, 0);

        out_ready = 1'b0;
        drive(2'b01, 4'hE, 1'b0, 4'b1100, 1'b1, 4'd3, 4'd4, 24'h10);
        step;
        in_valid = 1'b0;
        check("ls_word", out_instr, 32'hE5934010);
        out_ready = 1'b1;
        step;
        exp_ic++;
        check("ls_popped", instr_count, exp_ic);

        out_ready = 1'b0;
        drive(2'b10, 4'hE, 1'b1, 4'hF, 1'b0, 4'd7, 4'd7, 24'h3);
        step;
        in_valid = 1'b0;
        check("br_word", out_instr, 32'hEA000003);
`ifdef INSTR_ENCODER_NOP_FILL_EN
        check("br_nop_in_ready", in_ready, 0);
        check("br_count1", fifo_count, 1);
        step;
        check("br_nop_count", fifo_count, 2);
        check("br_back_idle", in_ready, 1);
        out_ready = 1'b1;
        step;
        exp_ic++;
        check("nop_word", out_instr, 0);
        check("nop_valid", out_valid, 1);
        check("br_pop_ic", instr_count, exp_ic);
        step;
        exp_ic++;
`else
        check("br_in_ready", in_ready, 1);
        check("br_count", fifo_count, 1);
        step;
        check("br_no_nop_in_ready", in_ready, 1);
        check("br_no_nop_count", fifo_count, 1);
        out_ready = 1'b1;
        step;
        exp_ic++;
`endif
        check("br_drained", fifo_count, 0);
        check("br_ic", instr_count, exp_ic);

        out_ready = 1'b0;
        drive(2'b00, 4'hE, 1'b1, 4'b0100, 1'b1, 4'd1, 4'd0, 24'h0);
        step;
        q.push_back(32'hE2910000);
        drive(2'b11, 4'hE, 1'b1, 4'b0100, 1'b1, 4'd1, 4'd5, 24'h5);
        step;
        in_valid = 1'b0;
        check("ill_err", err, 1);
        check("ill_count", fifo_count, 1);
        step;
        check("ill_err_pulse", err, 0);
        check("ill_count2", fifo_count, 1);
        check("ill_head", out_instr, 32'hE2910000);

        for (int r = 1; r < DEPTH; r++) begin
            drive(2'b00, 4'hE, 1'b1, 4'b0100, 1'b1, 4'd1, 4'(r), 24'(r));
            step;
            q.push_back(dp_word(4'(r), 12'(r)));
        end
        in_valid = 1'b0;
        check("full_count", fifo_count, DEPTH);
        check("full_in_ready", in_ready, 0);

        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            logic acc;
            drive(2'b00, 4'hE, 1'b1, 4'b0100, 1'b1, 4'd1, 4'(4 + k), 24'(12'h40 + k));
            #1;
            acc = q.size() < DEPTH;
            check("stream_head", out_instr, q[0]);
            check("stream_count", fifo_count, 32'(q.size()));
            check("stream_in_ready", in_ready, 32'(acc));
            step;
            if (acc) q.push_back(dp_word(4'(4 + k), 12'(12'h40 + k)));
            void'(q.pop_front());
            exp_ic++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (q.size() == 0) break;
            check("drain_head", out_instr, q[0]);
            step;
            void'(q.pop_front());
            exp_ic++;
        end
        check("drain_empty", out_valid, 0);
        check("drain_ic", instr_count, exp_ic);

        out_ready = 1'b0;
        drive(2'b00, 4'hE, 1'b1, 4'b0100, 1'b1, 4'd1, 4'd9, 24'h9);
        step;
        drive(2'b10, 4'hE, 1'b0, 4'h0, 1'b0, 4'd0, 4'd0, 24'h3);
        step;
        in_valid = 1'b0;
        reset = 1'b1;
        step;
        check("nrst_count", fifo_count, 0);
        check("nrst_valid", out_valid, 0);
        check("nrst_word", out_instr, 0);
        check("nrst_in_ready", in_ready, 0);
        check("nrst_ic", instr_count, 0);
        reset = 1'b0;
        #1 check("nrst_release_ready", in_ready, 1);
        step;
        check("nrst_no_nop", fifo_count, 0);
        check("nrst_ready_hold", in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
